// File: rtl/rapcla_pkg.sv
// Shared types and elaboration-time helpers for the rapcla carry-correction unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rapcla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, for sizing counters from constants.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    // Worst-case number of window hops needed to carry from bit W into bit N-1:
    // ceil((n-w-1)/(w+1)).
    function automatic int iter_max(input int n, input int w);
        return (n - w - 1 + w) / (w + 1);
    endfunction

endpackage

// File: rtl/rapcla_win_carry.sv
// Combinational windowed-carry generator: approximate carries, window propagate, carry->sum map.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
//   a_i, b_i   [N-1:0] operands
//   c_i        [N-1:0] carry vector to be mapped to a sum
//   appc_o     [N-1:0] carry out of bit i seen from bits max(0,i-W)..i only
//   pp_o       [N-1:0] window propagate &p[i:i-W] (zero for i<=W)
//   sum_appc_o [N:0]   sum built from appc_o
//   sum_c_o    [N:0]   sum built from c_i
module rapcla_win_carry #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] c_i,
    output logic [N-1:0] appc_o,
    output logic [N-1:0] pp_o,
    output logic [N:0]   sum_appc_o,
    output logic [N:0]   sum_c_o
);

    logic [N-1:0] p;
    logic [N-1:0] g;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Ripple a carry through the window [max(0,i-W) .. i] with zero carry-in.
    function automatic logic win_carry(input logic [N-1:0] pv, input logic [N-1:0] gv, input int i);
        logic c;
        c = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (j <= i && j >= i - W) c = gv[j] | (pv[j] & c);
        end
        return c;
    endfunction

    // s[0]=p[0], s[i]=p[i]^c[i-1], s[N]=c[N-1].
    function automatic logic [N:0] carry_to_sum(input logic [N-1:0] pv, input logic [N-1:0] cv);
        return {cv[N-1], pv ^ {cv[N-2:0], 1'b0}};
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign appc_o[i] = win_carry(p, g, i);
        if (i > W) begin : g_prop
            assign pp_o[i] = &p[i -: W + 1];
        end else begin : g_noprop
            assign pp_o[i] = 1'b0;
        end
    end

    assign sum_appc_o = carry_to_sum(p, appc_o);
    assign sum_c_o    = carry_to_sum(p, c_i);

endmodule

// File: rtl/rapcla_exact_corrector.sv
// Iterative carry corrector: approximate windowed sum in one cycle, then one window hop per cycle to exact.
// Latency: accept to out_valid = 2 + changing hops (2..2+ITER_MAX cycles); one op in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//   clk, rst (async, active-high); in_valid/in_ready/a/b operand side;
//   out_valid/out_ready/sum/sum_approx/err/iter result side.
module rapcla_exact_corrector
    import rapcla_pkg::*;
#(
    parameter int N   = 32,
    parameter int W   = 8,
    parameter int ITW = clog2((N + W) / (W + 1) + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N:0]     sum,
    output logic [N:0]     sum_approx,
    output logic           err,
    output logic [ITW-1:0] iter
);

    localparam logic [ITW-1:0] ITER_MAX = ITW'(iter_max(N, W));

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [N:0]     sum_q, sum_d, sum_approx_q, sum_approx_d;
    logic           err_q, err_d;
    logic [ITW-1:0] iter_q, iter_d;

    logic [N-1:0]   op_a, op_b, appc, pp, c_nxt;
    logic [N:0]     s_appc, s_c;

    // The single carry generator sees the live operands while idle (to load the
    // approximation) and the registered ones while iterating, so appc also
    // serves as the stored approximate carry vector for the error compare.
    assign op_a = (state_q == IDLE) ? a : a_q;
    assign op_b = (state_q == IDLE) ? b : b_q;

    rapcla_win_carry #(
        .N (N),
        .W (W)
    ) u_win_carry (
        .a_i        (op_a),
        .b_i        (op_b),
        .c_i        (c_q),
        .appc_o     (appc),
        .pp_o       (pp),
        .sum_appc_o (s_appc),
        .sum_c_o    (s_c)
    );

    // One hop: a carry W+1 bits below crosses a fully propagating window.
    assign c_nxt = appc | (pp & (c_q << (W + 1)));

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        sum_d        = sum_q;
        sum_approx_d = sum_approx_q;
        err_d        = err_q;
        iter_d       = iter_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d          = a;
                    b_d          = b;
                    c_d          = appc;
                    sum_approx_d = s_appc;
                    iter_d       = '0;
                    state_d      = ITER;
                end
            end
            ITER: begin
                if (c_nxt == c_q || iter_q == ITER_MAX) begin
                    sum_d   = s_c;
                    err_d   = (c_q != appc);
                    state_d = DONE;
                end else begin
                    c_d    = c_nxt;
                    iter_d = iter_q + ITW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            sum_q        <= '0;
            sum_approx_q <= '0;
            err_q        <= 1'b0;
            iter_q       <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            sum_q        <= sum_d;
            sum_approx_q <= sum_approx_d;
            err_q        <= err_d;
            iter_q       <= iter_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign sum        = sum_q;
    assign sum_approx = sum_approx_q;
    assign err        = err_q;
    assign iter       = iter_q;

endmodule

// File: tb/tb_rapcla_exact_corrector.sv
module tb_rapcla_exact_corrector;

    localparam int N   = 32;
    localparam int W   = 8;
    localparam int ITW = 3;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [N:0]     sum;
    logic [N:0]     sum_approx;
    logic           err;
    logic [ITW-1:0] iter;

    int n_checks;
    int n_err;

    rapcla_exact_corrector #(.N(N), .W(W), .ITW(ITW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .sum_approx (sum_approx),
        .err        (err),
        .iter       (iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference rap32_8: each window carry is the carry out of an ordinary
    // integer add of the operand slice [max(0,i-W) .. i].
    function automatic logic [N:0] approx_model(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] ap;
        logic [N:0]   r;
        logic [63:0]  m, sx, sy, s;
        int           lo;
        for (int i = 0; i < N; i++) begin
            lo = (i - W < 0) ? 0 : i - W;
            m  = (64'd1 << (i - lo + 1)) - 64'd1;
            sx = ({32'd0, x} >> lo) & m;
            sy = ({32'd0, y} >> lo) & m;
            s  = sx + sy;
            ap[i] = s[i - lo + 1];
        end
        r[0] = x[0] ^ y[0];
        for (int i = 1; i < N; i++) r[i] = x[i] ^ y[i] ^ ap[i-1];
        r[N] = ap[N-1];
        return r;
    endfunction

    // Present one operand pair, measure latency, optionally stall the consumer,
    // then release and confirm return to IDLE.
    task automatic run_op(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                          input logic [N:0] e_sum, input logic [N:0] e_apx, input logic e_err,
                          input int e_iter, input int e_lat, input int hold);
        int lat;
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        lat = 1;
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check({tag, ".latency"}, 64'(lat), 64'(e_lat));
        check({tag, ".sum"}, 64'(sum), 64'(e_sum));
        check({tag, ".sum_approx"}, 64'(sum_approx), 64'(e_apx));
        check({tag, ".err"}, 64'(err), 64'(e_err));
        check({tag, ".iter"}, 64'(iter), 64'(e_iter));
        if (hold > 0) begin
            // New operands offered while busy must be ignored.
            a = 32'h0000_0007; b = 32'h0000_0009; in_valid = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".hold_sum"}, 64'(sum), 64'(e_sum));
            check({tag, ".hold_apx"}, 64'(sum_approx), 64'(e_apx));
            check({tag, ".hold_iter"}, 64'(iter), 64'(e_iter));
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, ".release_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".release_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic [N:0]   e_sum, e_apx;
        int           cyc;
        logic         seen;

        n_checks = 0;
        n_err    = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.sum", 64'(sum), 64'd0);
        check("reset.sum_approx", 64'(sum_approx), 64'd0);
        check("reset.err", 64'(err), 64'd0);
        check("reset.iter", 64'(iter), 64'd0);

        // Directed vectors, expected values worked by hand.
        run_op("t1_5p3",    32'h0000_0005, 32'h0000_0003, 33'h0_0000_0008, 33'h0_0000_0008, 1'b0, 0, 2, 0);
        run_op("t2_worst",  32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 33'h0_FFFF_FC00, 1'b1, 3, 5, 0);
        run_op("t3_onehop", 32'h0000_03FF, 32'h0000_0001, 33'h0_0000_0400, 33'h0_0000_0000, 1'b1, 1, 3, 0);
        run_op("t4_stall",  32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 33'h0_FFFF_FC00, 1'b1, 3, 5, 10);
        // A 9-bit chain (g at bit 8, p over 9..16) fits in one window: no error.
        run_op("t_win9",    32'h0001_FF00, 32'h0000_0100, 33'h0_0002_0000, 33'h0_0002_0000, 1'b0, 0, 2, 0);
        // Carry out of the MSB lands in sum[N].
        run_op("t_msb",     32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 1'b0, 0, 2, 0);

        // Reset in the middle of the worst-case correction.
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5.rst_valid", 64'(out_valid), 64'd0);
        check("t5.rst_sum", 64'(sum), 64'd0);
        check("t5.rst_iter", 64'(iter), 64'd0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("t5.no_output", 64'(seen), 64'd0);
        check("t5.in_ready", 64'(in_ready), 64'd1);
        run_op("t5_after", 32'h0000_0001, 32'h0000_0001, 33'h0_0000_0002, 33'h0_0000_0002, 1'b0, 0, 2, 0);

        // Randomised operands and handshake timing against the reference model.
        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 3 == 0) rb = ~ra ^ (32'd1 << $urandom_range(0, 31));
            if (n % 7 == 0) rb = ~ra + 32'd1;
            e_sum = {1'b0, ra} + {1'b0, rb};
            e_apx = approx_model(ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            a = ra; b = rb; in_valid = 1'b1;
            cyc = 0;
            while (!in_ready && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                @(posedge clk);
                cyc++;
                #1;
            end
            check("rnd.valid", 64'(out_valid), 64'd1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check("rnd.sum", 64'(sum), 64'(e_sum));
            check("rnd.sum_approx", 64'(sum_approx), 64'(e_apx));
            check("rnd.err", 64'(err), 64'(e_sum != e_apx));
            check("rnd.iter_bound", 64'(iter <= 3'd3), 64'd1);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
